kronos_hcu: RTL

Hazard control unit for the Kronos ID→EX→WB integer pipeline. Gates instruction acceptance from decode and sequences the EX stage, including the multi-cycle serial shifter used for `ALU_SHIFT`. Tracks the destination register of the instruction in EX and in WB, then stalls or forwards operands to resolve read-after-write hazards. Drives the register-file write enable.

---
 rtl/kronos_hcu_pkg.sv | 26 ++
 rtl/kronos_hcu_hazard.sv | 27 ++
 rtl/kronos_hcu.sv | 99 +++++++++
 3 files changed

// File: rtl/kronos_hcu_pkg.sv
// Shared types for the Kronos hazard control unit: ALU result selects and the
// pipeline slot record tracked for the EX and WB stages.
package kronos_hcu_pkg;

  typedef enum logic [2:0] {
    ALU_ADDER = 3'd0,
    ALU_AND   = 3'd1,
    ALU_OR    = 3'd2,
    ALU_XOR   = 3'd3,
    ALU_LT    = 3'd4,
    ALU_SHIFT = 3'd5
  } aluSel_e;

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       rd_write;
  } hcuSlot_t;

  // x0 is hardwired to zero, so a write to it never creates a dependency
  function automatic logic slotHit(input hcuSlot_t slot, input logic rsRead,
                                   input logic [4:0] rs);
    return rsRead && (rs != 5'd0) && slot.vld && slot.rd_write && (slot.rd == rs);
  endfunction

endpackage

// File: rtl/kronos_hcu_hazard.sv
// Per-operand read-after-write check against the EX and WB slots.
// Returns {stall, fwd}; forwarding only exists when KRONOS_HCU_FWD_EN is defined.
module kronos_hcu_hazard
  import kronos_hcu_pkg::*;
(
  input  logic       rs_read_i,
  input  logic [4:0] rs_i,
  input  hcuSlot_t   ex_slot_i,
  input  hcuSlot_t   wb_slot_i,
  output logic [1:0] hazard_o
);

  logic exHit;
  logic wbHit;

  assign exHit = slotHit(ex_slot_i, rs_read_i, rs_i);
  assign wbHit = slotHit(wb_slot_i, rs_read_i, rs_i);

`ifdef KRONOS_HCU_FWD_EN
  // The EX result is not ready yet, so an EX hit wins over forwarding
  assign hazard_o = {exHit, wbHit & ~exHit};
`else
  // Without a bypass, wait for the register file write at the end of WB
  assign hazard_o = {exHit | wbHit, 1'b0};
`endif

endmodule

// File: rtl/kronos_hcu.sv
// Hazard control unit: gates decode acceptance, sequences EX (incl. serial shift)
// and retires through a one-cycle WB slot. Operand forwarding via KRONOS_HCU_FWD_EN.
module kronos_hcu
  import kronos_hcu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       decode_vld,
  output logic       decode_rdy,
  input  logic       decode_rs1_read,
  input  logic       decode_rs2_read,
  input  logic [4:0] decode_rs1,
  input  logic [4:0] decode_rs2,
  input  logic [4:0] decode_rd,
  input  logic       decode_rd_write,
  input  logic [2:0] decode_sel,
  input  logic [4:0] decode_shamt,
  input  logic       flush,
  output logic       ex_start,
  output logic       ex_step,
  output logic       ex_done,
  output logic       fwd_op1,
  output logic       fwd_op2,
  output logic       wb_en,
  output logic [4:0] wb_rd,
  output logic       busy
);

  hcuSlot_t   exSlot_q, exSlot_d;
  hcuSlot_t   wbSlot_q, wbSlot_d;
  logic [4:0] shiftCnt_q, shiftCnt_d;
  logic [1:0] hazRs1, hazRs2;
  logic       stall;
  logic       accept;

  kronos_hcu_hazard u_haz_rs1 (
    .rs_read_i (decode_rs1_read),
    .rs_i      (decode_rs1),
    .ex_slot_i (exSlot_q),
    .wb_slot_i (wbSlot_q),
    .hazard_o  (hazRs1)
  );

  kronos_hcu_hazard u_haz_rs2 (
    .rs_read_i (decode_rs2_read),
    .rs_i      (decode_rs2),
    .ex_slot_i (exSlot_q),
    .wb_slot_i (wbSlot_q),
    .hazard_o  (hazRs2)
  );

  assign stall = hazRs1[1] | hazRs2[1];

  // A flush kills the EX slot outright, so it can neither step nor complete
  assign ex_done    = exSlot_q.vld & (shiftCnt_q == 5'd0) & ~flush;
  assign ex_step    = exSlot_q.vld & (shiftCnt_q != 5'd0) & ~flush;
  assign decode_rdy = ~rst & ~flush & (~exSlot_q.vld | ex_done) & ~stall;
  assign accept     = decode_vld & decode_rdy;
  assign ex_start   = accept;

  assign fwd_op1 = ~rst & hazRs1[0];
  assign fwd_op2 = ~rst & hazRs2[0];
  assign wb_en   = wbSlot_q.vld & wbSlot_q.rd_write;
  assign wb_rd   = wbSlot_q.vld ? wbSlot_q.rd : 5'd0;
  assign busy    = exSlot_q.vld | wbSlot_q.vld;

  always_comb begin
    exSlot_d   = exSlot_q;
    shiftCnt_d = shiftCnt_q;
    wbSlot_d   = '0;
    if (ex_done) wbSlot_d = exSlot_q;
    if (flush) begin
      exSlot_d   = '0;
      shiftCnt_d = 5'd0;
    end else if (accept) begin
      exSlot_d.vld      = 1'b1;
      exSlot_d.rd       = decode_rd;
      exSlot_d.rd_write = decode_rd_write;
      shiftCnt_d        = (decode_sel == ALU_SHIFT) ? decode_shamt : 5'd0;
    end else if (ex_done) begin
      exSlot_d = '0;
    end else if (ex_step) begin
      shiftCnt_d = shiftCnt_q - 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exSlot_q   <= '0;
      wbSlot_q   <= '0;
      shiftCnt_q <= 5'd0;
    end else begin
      exSlot_q   <= exSlot_d;
      wbSlot_q   <= wbSlot_d;
      shiftCnt_q <= shiftCnt_d;
    end
  end

endmodule
